// File: rtl/popcount_neuron_sched.sv
// Ternary-neuron scheduler: streams positive then negative 16-bit chunks through one
// external popcount unit, accumulates both counts and thresholds the signed difference.
module popcount_neuron_sched #(
    parameter int unsigned NUM_CHUNKS = 4,
    parameter int unsigned ACC_W      = 8,
    parameter int unsigned THR_W      = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*NUM_CHUNKS-1:0]  in_pos,
    input  logic [16*NUM_CHUNKS-1:0]  in_neg,
    input  logic [THR_W-1:0]          in_thr,
    output logic [15:0]               pc_a,
    input  logic [4:0]                pc_count,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W:0]            out_sum,
    output logic [1:0]                out_act,
    output logic                      busy
);

    localparam int unsigned VEC_W = 16 * NUM_CHUNKS;
    localparam int unsigned IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned ADD_W = ((ACC_W > 5) ? ACC_W : 5) + 1;
    localparam int unsigned CMP_W = ((ACC_W > THR_W) ? ACC_W : THR_W) + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POS  = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [VEC_W-1:0]   r_pos,       w_pos_nxt;
    logic [VEC_W-1:0]   r_neg,       w_neg_nxt;
    logic [THR_W-1:0]   r_thr,       w_thr_nxt;
    logic [ACC_W-1:0]   r_acc_p,     w_acc_p_nxt;
    logic [ACC_W-1:0]   r_acc_n,     w_acc_n_nxt;
    logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
    logic [15:0]        r_pc_a,      w_pc_a_nxt;
    logic               r_in_ready,  w_in_ready_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [ACC_W:0]     r_out_sum,   w_out_sum_nxt;
    logic [1:0]         r_out_act,   w_out_act_nxt;
    logic               r_busy,      w_busy_nxt;

    logic [15:0]               w_pos_chunk [NUM_CHUNKS];
    logic [15:0]               w_neg_chunk [NUM_CHUNKS];
    logic [IDX_W-1:0]          w_idx_inc;
    logic [ACC_W-1:0]          w_acc_p_add;
    logic [ACC_W-1:0]          w_acc_n_add;
    logic signed [ACC_W:0]     w_diff;
    logic signed [CMP_W-1:0]   w_sum_ext;
    logic signed [CMP_W-1:0]   w_thr_ext;
    logic [1:0]                w_act;

    // Accumulator add that clamps at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                  input logic [4:0]       inc);
        logic [ADD_W-1:0] s;
        s = ADD_W'(acc) + ADD_W'(inc);
        if (s > ADD_W'({ACC_W{1'b1}})) begin
            return {ACC_W{1'b1}};
        end
        return ACC_W'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            w_pos_chunk[k] = r_pos[16*k +: 16];
            w_neg_chunk[k] = r_neg[16*k +: 16];
        end
    end

    assign w_idx_inc   = IDX_W'(r_idx + 1'b1);
    assign w_acc_p_add = sat_add(r_acc_p, pc_count);
    assign w_acc_n_add = sat_add(r_acc_n, pc_count);

    // Final result uses the last negative chunk's count so it lands the cycle DONE is entered.
    assign w_diff    = $signed((ACC_W+1)'(r_acc_p) - (ACC_W+1)'(w_acc_n_add));
    assign w_sum_ext = {{(CMP_W-ACC_W-1){w_diff[ACC_W]}}, w_diff};
    assign w_thr_ext = {{(CMP_W-THR_W){1'b0}}, r_thr};

    always_comb begin
        w_act = 2'b00;
        if (w_sum_ext >= w_thr_ext) begin
            w_act = 2'b01;
        end else if (w_sum_ext <= -w_thr_ext) begin
            w_act = 2'b11;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_neg_nxt       = r_neg;
        w_thr_nxt       = r_thr;
        w_acc_p_nxt     = r_acc_p;
        w_acc_n_nxt     = r_acc_n;
        w_idx_nxt       = r_idx;
        w_pc_a_nxt      = r_pc_a;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_act_nxt   = r_out_act;

        case (r_state)
            S_IDLE: begin
                w_pc_a_nxt = 16'h0000;
                if (in_valid && r_in_ready) begin
                    w_pos_nxt   = in_pos;
                    w_neg_nxt   = in_neg;
                    w_thr_nxt   = in_thr;
                    w_acc_p_nxt = '0;
                    w_acc_n_nxt = '0;
                    w_idx_nxt   = '0;
                    w_pc_a_nxt  = in_pos[15:0];
                    w_state_nxt = S_POS;
                end
            end
            S_POS: begin
                w_acc_p_nxt = w_acc_p_add;
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt   = '0;
                    w_pc_a_nxt  = w_neg_chunk[0];
                    w_state_nxt = S_NEG;
                end else begin
                    w_idx_nxt  = w_idx_inc;
                    w_pc_a_nxt = w_pos_chunk[w_idx_inc];
                end
            end
            S_NEG: begin
                w_acc_n_nxt = w_acc_n_add;
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt       = '0;
                    w_pc_a_nxt      = 16'h0000;
                    w_out_valid_nxt = 1'b1;
                    w_out_sum_nxt   = w_diff;
                    w_out_act_nxt   = w_act;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_idx_nxt  = w_idx_inc;
                    w_pc_a_nxt = w_neg_chunk[w_idx_inc];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_neg       <= '0;
            r_thr       <= '0;
            r_acc_p     <= '0;
            r_acc_n     <= '0;
            r_idx       <= '0;
            r_pc_a      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_act   <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_neg       <= w_neg_nxt;
            r_thr       <= w_thr_nxt;
            r_acc_p     <= w_acc_p_nxt;
            r_acc_n     <= w_acc_n_nxt;
            r_idx       <= w_idx_nxt;
            r_pc_a      <= w_pc_a_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_act   <= w_out_act_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign pc_a      = r_pc_a;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_act   = r_out_act;
    assign busy      = r_busy;

endmodule
